uart_tx_ctrl: RTL and testbench

UART transmit controller. Drains the UART TX FIFO one byte at a time and serialises each byte as an 8N1 frame on `tx`. Sits between the TX `fifo` instance (its read port) and the UART pin. It is the only agent that asserts the TX FIFO's `readEn`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 23 ++
 rtl/uart_tx_ctrl.sv | 94 +++++++++
 tb/tb_uart_tx_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitTick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] cnt;

  assign bitTick = (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (bitTick)   cnt <= '0;
    else                cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops one byte per frame from the TX FIFO and shifts it out as 8N1.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txEn,
  input  logic       fifoEmpty,
  input  logic [7:0] fifoData,
  output logic       fifoReadEn,
  output logic       tx,
  output logic       busy,
  output logic       txDone
);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bitIdx;
  logic                 bitTick;
  logic                 clear;

  // Baud counter only runs while a frame is on the wire.
  assign clear  = (state == IDLE) || (state == POP) || (state == LOAD);
  assign txDone = (state == STOP) && bitTick;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .bitTick (bitTick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifoReadEn <= 1'b0;
      shreg      <= '0;
      bitIdx     <= '0;
    end else begin
      fifoReadEn <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (txEn && !fifoEmpty) begin
            state      <= POP;
            fifoReadEn <= 1'b1;
            busy       <= 1'b1;
          end
        end
        POP: state <= LOAD;
        LOAD: begin
          // FIFO output became valid on the edge that closed the POP cycle.
          shreg  <= fifoData;
          bitIdx <= '0;
          tx     <= 1'b0;
          state  <= START;
        end
        START: if (bitTick) begin
          tx    <= shreg[0];
          state <= DATA;
        end
        DATA: if (bitTick) begin
          if (bitIdx == 3'(DATA_BITS - 1)) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tx     <= shreg[1];
            shreg  <= shreg >> 1;
            bitIdx <= bitIdx + 3'd1;
          end
        end
        STOP: if (bitTick) begin
          if (txEn && !fifoEmpty) begin
            state      <= POP;
            fifoReadEn <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4 and a small synchronous FIFO model.
module tb_uart_tx_ctrl;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       txEn = 1'b0;
  logic       fifoEmpty;
  logic [7:0] fifoData = 8'h00;
  logic       fifoReadEn, tx, busy, txDone;

  logic       wrEn = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic [7:0] mem [16];
  logic [4:0] wp = '0, rp = '0;
  int         underflow = 0;
  int         nre = 0, ndone = 0;
  int         nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .txEn(txEn), .fifoEmpty(fifoEmpty), .fifoData(fifoData),
    .fifoReadEn(fifoReadEn), .tx(tx), .busy(busy), .txDone(txDone)
  );

  // FIFO model: dataOut updates on the edge that ends the readEn cycle
  assign fifoEmpty = (wp == rp);
  always @(posedge clk) begin
    if (wrEn) begin
      mem[wp[3:0]] <= wrData;
      wp <= wp + 5'd1;
    end
    if (fifoReadEn) begin
      if (wp == rp) underflow <= underflow + 1;
      else begin
        fifoData <= mem[rp[3:0]];
        rp <= rp + 5'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (fifoReadEn) nre++;
    if (txDone) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    wrEn = 1'b1; wrData = b;
    tick(1);
    wrEn = 1'b0;
  endtask

  // Waits for START, samples all 40 cycles; returns at the first cycle after STOP.
  task automatic get_frame(input string tag, input logic [7:0] b, input int drop_bit);
    logic [9:0] bits, exp;
    int w, glitch;
    w = 0; glitch = 0; bits = '0;
    while (tx !== 1'b0 && w < 200) begin tick(1); w++; end
    chk({tag, "_start_seen"}, (w < 200), 1);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < CPB; j++) begin
        if (j == 0) bits[k] = tx;
        else if (tx !== bits[k]) glitch++;
        if (k == drop_bit && j == 0) txEn = 1'b0;
        tick(1);
      end
    exp = {1'b1, b, 1'b0};
    chk({tag, "_bits"}, {22'd0, bits}, {22'd0, exp});
    chk({tag, "_hold"}, glitch, 0);
  endtask

  int bad, r0, d0, g;

  initial begin
    // 1. reset
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
      chk("rst_re", fifoReadEn, 0); chk("rst_done", txDone, 0);
    end
    reset = 1'b0; txEn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0 || fifoReadEn !== 1'b0 || txDone !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // 2. single byte with exact POP/START timing
    r0 = nre; d0 = ndone;
    wr(8'hA5);
    chk("t2_re_n", fifoReadEn, 0);
    tick(1); chk("t2_re_n1", fifoReadEn, 1); chk("t2_busy_n1", busy, 1);
    tick(1); chk("t2_re_n2", fifoReadEn, 0); chk("t2_tx_n2", tx, 1);
    tick(1); chk("t2_tx_n3", tx, 0);
    get_frame("t2", 8'hA5, -1);
    chk("t2_busy_end", busy, 0);
    chk("t2_re_cnt", nre - r0, 1);
    chk("t2_done_cnt", ndone - d0, 1);

    // 3. back-to-back
    r0 = nre;
    wr(8'hFF); wr(8'h00);
    get_frame("t3a", 8'hFF, -1);
    g = 0;
    while (tx === 1'b1 && g < 50) begin tick(1); g++; end
    chk("t3_gap", g, 2);
    get_frame("t3b", 8'h00, -1);
    tick(3);
    chk("t3_re_cnt", nre - r0, 2);
    chk("t3_empty", fifoEmpty, 1);
    chk("t3_busy", busy, 0);

    // 4. enable gating
    txEn = 1'b0; r0 = nre;
    wr(8'h3C);
    tick(50);
    chk("t4_gated_re", nre - r0, 0);
    chk("t4_gated_busy", busy, 0);
    txEn = 1'b1;
    get_frame("t4a", 8'h3C, -1);
    tick(3);
    r0 = nre;
    wr(8'h81); wr(8'h42);
    get_frame("t4b", 8'h81, 3);
    tick(20);
    chk("t4_drop_re", nre - r0, 1);
    chk("t4_left", fifoEmpty, 0);
    chk("t4_drop_busy", busy, 0);
    txEn = 1'b1;
    get_frame("t4c", 8'h42, -1);
    tick(3);

    // 5. reset during DATA bit 3
    wr(8'h96); wr(8'h5A);
    g = 0;
    while (tx !== 1'b0 && g < 50) begin tick(1); g++; end
    chk("t5_start_seen", (g < 50), 1);
    tick(17);
    reset = 1'b1;
    tick(1);
    chk("t5_tx", tx, 1); chk("t5_busy", busy, 0); chk("t5_re", fifoReadEn, 0);
    reset = 1'b0;
    tick(1); chk("t5_re_n1", fifoReadEn, 1);
    tick(1); chk("t5_tx_n2", tx, 1);
    tick(1); chk("t5_tx_n3", tx, 0);
    get_frame("t5", 8'h5A, -1);
    tick(3);

    // 6. empty protection
    r0 = nre;
    wr(8'h11);
    get_frame("t6", 8'h11, -1);
    tick(50);
    chk("t6_re_cnt", nre - r0, 1);
    chk("t6_underflow", underflow, 0);
    chk("t6_empty", fifoEmpty, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
